// File: rtl/key_token_ctrl.sv
// Keypad debouncer and token queue: confirms decoder strobes, emits one token per press into a 4-deep FIFO.
// Optional macro KEY_AUTOREPEAT_EN re-pushes the held key every REPEAT_DLY cycles.
module key_token_ctrl #(
  parameter int unsigned DEBOUNCE_N = 2,
  parameter int unsigned RELEASE_TO = 450000,
  parameter int unsigned REPEAT_DLY = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_code,
  input  logic       key_strobe,
  output logic [3:0] tok_data,
  output logic       tok_valid,
  input  logic       tok_ready,
  output logic       key_held,
  output logic       tok_ovf,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONFIRM = 2'd1,
    HELD    = 2'd2
  } state_e;

  localparam logic [3:0]  DEB = 4'(DEBOUNCE_N);
  localparam logic [19:0] REL = 20'(RELEASE_TO);

  state_e      state_q, state_d;
  logic [3:0]  cand_q, cand_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [19:0] timer_q, timer_d;
  logic        held_q;
  logic        match;
  logic [19:0] timer_inc;
  logic [3:0]  cnt_inc;
  logic        push;
  logic [3:0]  push_val;

`ifdef KEY_AUTOREPEAT_EN
  localparam logic [26:0] REP = 27'(REPEAT_DLY);
  logic [26:0] rep_q, rep_d;
  logic [26:0] rep_inc;
  assign rep_inc = rep_q + 27'd1;
`else
  // REPEAT_DLY has no effect in this build; no repeat counter exists.
  if (REPEAT_DLY == 0) begin : g_no_repeat
  end
`endif

  assign match     = key_strobe && (key_code == cand_q);
  assign timer_inc = timer_q + 20'd1;
  assign cnt_inc   = cnt_q + 4'd1;

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    timer_d  = timer_q;
    push     = 1'b0;
    push_val = cand_q;
`ifdef KEY_AUTOREPEAT_EN
    rep_d    = 27'd0;
`endif
    case (state_q)
      IDLE: begin
        if (key_strobe) begin
          cand_d   = key_code;
          cnt_d    = 4'd1;
          timer_d  = 20'd0;
          push_val = key_code;
          if (DEB == 4'd1) begin
            state_d = HELD;
            push    = 1'b1;
          end else begin
            state_d = CONFIRM;
          end
        end
      end
      CONFIRM: begin
        if (match) begin
          cnt_d   = cnt_inc;
          timer_d = 20'd0;
          if (cnt_inc == DEB) begin
            state_d = HELD;
            push    = 1'b1;
          end
        end else if (key_strobe) begin
          cand_d  = key_code;
          cnt_d   = 4'd1;
          timer_d = 20'd0;
        end else if (timer_inc == REL) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
          timer_d = 20'd0;
        end else begin
          timer_d = timer_inc;
        end
      end
      HELD: begin
        // A matching strobe beats expiry; foreign codes never refresh the timer.
        if (match) begin
          timer_d = 20'd0;
        end else if (timer_inc == REL) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
          timer_d = 20'd0;
        end else begin
          timer_d = timer_inc;
        end
`ifdef KEY_AUTOREPEAT_EN
        if (state_d == HELD) begin
          if (rep_inc == REP) begin
            push  = 1'b1;
            rep_d = 27'd0;
          end else begin
            rep_d = rep_inc;
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cand_q  <= 4'd0;
      cnt_q   <= 4'd0;
      timer_q <= 20'd0;
      held_q  <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      rep_q   <= 27'd0;
`endif
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      held_q  <= (state_d == HELD);
`ifdef KEY_AUTOREPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  // Token FIFO: 4 entries, pointers wrap mod 4, occupancy 0..4.
  logic [3:0] mem_q [4];
  logic [1:0] wr_q, rd_q;
  logic [2:0] occ_q;
  logic       ovf_q;
  logic       pop, full, do_push;

  assign pop     = (occ_q != 3'd0) && tok_ready;
  assign full    = (occ_q == 3'd4);
  assign do_push = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) mem_q[i] <= 4'd0;
      wr_q  <= 2'd0;
      rd_q  <= 2'd0;
      occ_q <= 3'd0;
      ovf_q <= 1'b0;
    end else begin
      if (pop) rd_q <= rd_q + 2'd1;
      if (do_push) begin
        mem_q[wr_q] <= push_val;
        wr_q        <= wr_q + 2'd1;
      end
      case ({do_push, pop})
        2'b10:   occ_q <= occ_q + 3'd1;
        2'b01:   occ_q <= occ_q - 3'd1;
        default: occ_q <= occ_q;
      endcase
      ovf_q <= push && full && !pop;
    end
  end

  assign tok_data  = mem_q[rd_q];
  assign tok_valid = (occ_q != 3'd0);
  assign key_held  = held_q;
  assign tok_ovf   = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_key_token_ctrl.sv
// Bench for key_token_ctrl: directed press scenarios plus random traffic against a timestamp-based model.
module tb_key_token_ctrl;

  localparam int DEB = 2;
  localparam int REL = 20;
  localparam int REP = 50;

  logic       clk;
  logic       rst;
  logic [3:0] key_code;
  logic       key_strobe;
  logic [3:0] tok_data;
  logic       tok_valid;
  logic       tok_ready;
  logic       key_held;
  logic       tok_ovf;
  logic [1:0] dbg_state;

  key_token_ctrl #(
    .DEBOUNCE_N(DEB),
    .RELEASE_TO(REL),
    .REPEAT_DLY(REP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_code  (key_code),
    .key_strobe(key_strobe),
    .tok_data  (tok_data),
    .tok_valid (tok_valid),
    .tok_ready (tok_ready),
    .key_held  (key_held),
    .tok_ovf   (tok_ovf),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model: press tracked by timestamps, FIFO as a queue
  logic [3:0] exp_q[$];
  logic [3:0] got_q[$];
  int   cyc = 0;
  bit   m_busy, m_held, m_ovf;
  logic [3:0] m_cand;
  int   m_n, m_last, m_acc;
  int   n_ovf = 0;

  task automatic model_step(input logic s, input logic [3:0] c, input logic r, input logic rs);
    bit push;
    logic [3:0] pval;
    if (rs) begin
      exp_q.delete();
      m_busy = 0; m_held = 0; m_ovf = 0; m_cand = 4'd0; m_n = 0;
      return;
    end
    push = 0;
    pval = m_cand;
    if (!m_busy) begin
      if (s) begin
        m_cand = c; m_n = 1; m_last = cyc; m_busy = 1; pval = c;
        if (DEB == 1) begin m_held = 1; m_acc = cyc; push = 1; end
      end
    end else if (!m_held) begin
      if (s && c == m_cand) begin
        m_n++; m_last = cyc;
        if (m_n == DEB) begin m_held = 1; m_acc = cyc; push = 1; end
      end else if (s) begin
        m_cand = c; m_n = 1; m_last = cyc;
      end else if (cyc - m_last >= REL) begin
        m_busy = 0;
      end
    end else begin
      if (s && c == m_cand) m_last = cyc;
      else if (cyc - m_last >= REL) begin m_busy = 0; m_held = 0; end
`ifdef KEY_AUTOREPEAT_EN
      if (m_held && cyc > m_acc && ((cyc - m_acc) % REP) == 0) push = 1;
`endif
    end
    if (exp_q.size() > 0 && r) void'(exp_q.pop_front());
    m_ovf = 0;
    if (push) begin
      if (exp_q.size() == 4) m_ovf = 1;
      else exp_q.push_back(pval);
    end
  endtask

  // driver
  task automatic tick(input logic s, input logic [3:0] c, input logic r, input logic rs);
    key_strobe = s;
    key_code   = c;
    tok_ready  = r;
    rst        = rs;
    if (tok_valid === 1'b1 && r && !rs) got_q.push_back(tok_data);
    model_step(s, c, r, rs);
    @(posedge clk);
    #1;
    cyc++;
    check_eq("tok_valid", 32'(tok_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) check_eq("tok_data", 32'(tok_data), 32'(exp_q[0]));
    check_eq("key_held", 32'(key_held), 32'(m_held));
    check_eq("tok_ovf", 32'(tok_ovf), 32'(m_ovf));
    if (tok_ovf === 1'b1) n_ovf++;
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) tick(1'b0, 4'd0, r, 1'b0);
  endtask

  // scoreboard of tokens actually consumed in a scenario
  task automatic expect_tokens(input string tag, input logic [15:0] vals, input int n);
    logic [3:0] g;
    check_eq({tag, "_count"}, 32'(got_q.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      g = (i < got_q.size()) ? got_q[i] : 4'hx;
      check_eq({tag, "_tok"}, 32'(g), 32'(vals[4*i +: 4]));
    end
    got_q.delete();
  endtask

  int held_cnt;

  initial begin
    key_strobe = 1'b0; key_code = 4'd0; tok_ready = 1'b1; rst = 1'b1;
    tick(1'b0, 4'd0, 1'b1, 1'b1);
    tick(1'b0, 4'd0, 1'b1, 1'b1);
    check_eq("rst_data", 32'(tok_data), 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'd0);

    // single press of 5
    for (int i = 0; i < 40; i++) tick(i == 10 || i == 15, 4'd5, 1'b1, 1'b0);
    idle(10, 1'b1);
    expect_tokens("s1", 16'h0005, 1);

    // candidate changes from 5 to 9 before confirmation
    for (int i = 0; i < 50; i++)
      tick(i == 10 || i == 15 || i == 20, (i == 10) ? 4'd5 : 4'd9, 1'b1, 1'b0);
    idle(10, 1'b1);
    expect_tokens("s2", 16'h0009, 1);

    // key 3 held by periodic strobes, then released
    held_cnt = 0;
    for (int i = 0; i < 260; i++) begin
      tick((i == 0) || (i >= 5 && i <= 205 && ((i - 5) % 10) == 0), 4'd3, 1'b1, 1'b0);
      if (i >= 205 && key_held === 1'b1) held_cnt++;
    end
    check_eq("s3_hold", 32'(held_cnt), 32'd20);
    expect_tokens("s3", 16'h0003, 1);

    // five presses with consumer stalled, then drain
    n_ovf = 0;
    for (int k = 0; k < 5; k++) begin
      logic [3:0] code;
      code = (k == 4) ? 4'd6 : 4'(k + 1);
      tick(1'b1, code, 1'b0, 1'b0);
      idle(2, 1'b0);
      tick(1'b1, code, 1'b0, 1'b0);
      idle(30, 1'b0);
    end
    check_eq("s4_ovf", 32'(n_ovf), 32'd1);
    idle(10, 1'b1);
    expect_tokens("s4", 16'h4321, 4);

    // reset mid-press discards it
    tick(1'b1, 4'd7, 1'b1, 1'b0);
    idle(2, 1'b1);
    tick(1'b0, 4'd0, 1'b1, 1'b1);
    idle(2, 1'b1);
    tick(1'b1, 4'd7, 1'b1, 1'b0);
    idle(30, 1'b1);
    expect_tokens("s5a", 16'h0000, 0);
    tick(1'b1, 4'd7, 1'b1, 1'b0);
    idle(4, 1'b1);
    tick(1'b1, 4'd7, 1'b1, 1'b0);
    idle(30, 1'b1);
    expect_tokens("s5b", 16'h0007, 1);

    // key 2 held 130 cycles after acceptance
    for (int i = 0; i < 170; i++)
      tick((i == 0) || (i >= 5 && i <= 135 && ((i - 5) % 10) == 0), 4'd2, 1'b1, 1'b0);
`ifdef KEY_AUTOREPEAT_EN
    expect_tokens("s6", 16'h0222, 3);
`else
    expect_tokens("s6", 16'h0002, 1);
`endif

    // random traffic: relaxed consumer, then mostly stalled consumer
    for (int i = 0; i < 2500; i++)
      tick($urandom_range(0, 3) == 0, 4'($urandom_range(0, 3)),
           $urandom_range(0, 2) != 0, $urandom_range(0, 499) == 0);
    for (int i = 0; i < 2500; i++)
      tick($urandom_range(0, 2) == 0, 4'($urandom_range(0, 1)),
           $urandom_range(0, 5) == 0, $urandom_range(0, 999) == 0);
    idle(40, 1'b1);
    got_q.delete();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/key_token_ctrl.md
KEY_TOKEN_CTRL -- requirements
Module: key_token_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_N, default 2, giving the number of consecutive matching decoder strobes required to accept a key (1..15).
REQ-002 The block SHALL have parameter RELEASE_TO, default 450000, giving the number of strobe-free cycles that marks a key as released (1..2^20-1; exceeds one 100 MHz keypad scan period).
REQ-003 The block SHALL have parameter REPEAT_DLY, default 50000000, giving the auto-repeat interval in cycles (1..2^27-1).
REQ-004 clk  input  1  100 MHz system clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 key_code  input  4  key value from the keypad decoder (DecodeOut).
REQ-007 key_strobe  input  1  one-cycle pulse from the decoder: key_code holds a new detection (DecoderState).
REQ-008 tok_data  output  4  token at FIFO head.
REQ-009 tok_valid  output  1  FIFO non-empty.
REQ-010 tok_ready  input  1  consumer accepts head token when tok_valid and tok_ready are both high.
REQ-011 key_held  output  1  high while a key is accepted and not yet released.
REQ-012 tok_ovf  output  1  one-cycle pulse when a token is dropped because the FIFO is full.

Function
REQ-013 The FSM SHALL have states IDLE, CONFIRM and HELD, with a 4-bit candidate code register, a 4-bit strobe counter and a 20-bit silence timer.
REQ-014 In IDLE, a key_strobe SHALL latch key_code as candidate, set the count to 1, clear the timer and enter CONFIRM; if DEBOUNCE_N=1 it SHALL enter HELD instead and push the token.
REQ-015 In CONFIRM, a strobe with a matching code SHALL increment the count and clear the timer; when the count reaches DEBOUNCE_N it SHALL push the candidate into the FIFO and enter HELD.
REQ-016 In CONFIRM, a strobe with a different code SHALL restart CONFIRM with the new candidate and a count of 1.
REQ-017 In CONFIRM or HELD, the silence timer SHALL increment every cycle without a matching strobe; on reaching RELEASE_TO the FSM SHALL return to IDLE.
REQ-018 In HELD, a matching strobe SHALL clear the timer; a non-matching strobe SHALL be ignored and SHALL NOT clear the timer (no rollover).
REQ-019 If a matching strobe and timer expiry occur in the same cycle, the strobe SHALL win: the timer clears and the state is retained.
REQ-020 key_held SHALL be registered and high exactly while the FSM is in HELD.
REQ-021 The FIFO SHALL be 4 entries deep, 4 bits wide, with tok_data/tok_valid driven from registers (no combinational path from key_strobe).
REQ-022 A push SHALL become visible on tok_valid on the cycle after the accepting strobe (latency 1).
REQ-023 A push while full and not popping SHALL drop the token and pulse tok_ovf for 1 cycle; FIFO contents SHALL be unchanged.
REQ-024 A simultaneous push and pop while full SHALL accept the push with no tok_ovf.
REQ-025 A simultaneous push and pop while empty SHALL leave the FIFO holding the pushed token.
REQ-026 Read and write pointers SHALL wrap modulo 4; occupancy SHALL use a 3-bit count (0..4).

Reset
REQ-027 rst SHALL put the FSM in IDLE, clear the count, timer, candidate, FIFO pointers and occupancy, and drive tok_valid=0, tok_data=0, key_held=0 and tok_ovf=0 on the next edge.
REQ-028 rst asserted mid-press SHALL discard the press; subsequent strobes of the same key SHALL be re-debounced from IDLE.
REQ-029 rst SHALL take priority over all other inputs in the same cycle.

Configuration
REQ-030 Macro KEY_AUTOREPEAT_EN: when defined, HELD SHALL run a 27-bit repeat counter that re-pushes the candidate every REPEAT_DLY cycles after acceptance; the counter SHALL be cleared on HELD entry and on reset.
REQ-031 When KEY_AUTOREPEAT_EN is not defined, exactly one token SHALL be pushed per accepted press, REPEAT_DLY SHALL be unused, and no repeat counter SHALL be synthesised.

Verification (bench parameters: DEBOUNCE_N=2, RELEASE_TO=20, REPEAT_DLY=50)
REQ-032 Strobes code 5 at cycles 10 and 15, tok_ready=1 -> tok_valid high for 1 cycle at cycle 16 with tok_data=5; key_held rises at cycle 16.
REQ-033 Strobe code 5 at cycle 10 then code 9 at cycles 15 and 20 -> a single token 9; no token 5.
REQ-034 Key 3 accepted, then strobes of code 3 every 10 cycles for 200 cycles, then none -> one token only; key_held falls 20 cycles after the last strobe.
REQ-035 tok_ready=0, five distinct presses each separated by silence -> FIFO holds the first 4 tokens in order, tok_ovf pulses once on the 5th press; then tok_ready=1 drains the 4 tokens in order.
REQ-036 rst pulsed between the first and second strobe of code 7 -> no token; two further strobes of 7 -> one token 7.
REQ-037 With KEY_AUTOREPEAT_EN, key 2 held for 130 cycles after acceptance -> 3 tokens of value 2 (at acceptance, +50, +100); without the macro -> 1 token.
